decoder2x4_hold: RTL and testbench
==================================

Name: decoder2x4_hold

Overview:
- Registered 2-to-4 one-hot decoder; the receive-side counterpart of the team's 4x2 encoder.
- Accepts a 2-bit code through a valid/ready handshake and drives the matching one-hot line high for a programmable number of cycles.
- Sits between an encoded control bus and downstream select/strobe logic that needs a one-hot pulse of guaranteed width.

Parameters:
HOLD_CYCLES, 4, cycles each decoded one-hot output stays asserted; legal range 1..255.
CNT_W, 8, width of each per-line hit counter; used only when DEC2X4_HIT_CNT_EN is defined.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  block enable; low blocks new accepts and aborts an active hold.
code_in  input  2  encoded line index: 0 maps to y[0], 3 maps to y[3].
in_valid  input  1  code_in is valid this cycle.
in_ready  output  1  block can accept a code this cycle.
y  output  4  registered one-hot decoded output; all zero when idle.
out_valid  output  1  high while y is non-zero.
busy  output  1  high while in HOLD.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, y=4'b0000, out_valid=0, busy=0, hold counter=0, hit counters=0. in_ready is combinational and reads 0 while rst_n is low.
- FSM states:
  - IDLE: y=0.
  - HOLD: y is one-hot.
- in_ready = (state==IDLE) && en && rst_n. It is combinational and never depends on in_valid.
- Accept occurs when in_valid && in_ready on a rising edge.
- On accept:
  - Next cycle: y = 4'b0001 << code_in, out_valid=1, busy=1, state goes to HOLD.
  - Hold counter loads HOLD_CYCLES-1.
  - Latency is 1 cycle from accept edge to y.
- In HOLD with en high:
  - Counter decrements by 1 each cycle.
  - In the cycle the counter reads 0, the next edge clears y and out_valid and returns the FSM to IDLE.
  - y is therefore high for exactly HOLD_CYCLES consecutive cycles.
- HOLD_CYCLES=1: y is high for a single cycle, and the FSM returns to IDLE on the next edge.
- In HOLD, in_ready=0, so in_valid is ignored and no code is queued or buffered.
- Back-to-back codes: at least one idle cycle with y=0 separates consecutive pulses, which guarantees a break between lines.
- en deasserted during HOLD: the next edge clears y, out_valid and busy and enters IDLE (abort). No partial resume.
- en deasserted during IDLE: no accept; outputs stay zero.
- rst_n asserted mid-HOLD: y clears immediately (asynchronously) and the pulse is truncated.
- y is never multi-hot; exactly zero or one bit is set at any time.
- Counter width is 8 bits. HOLD_CYCLES outside 1..255 is illegal; the implementation must flag it with a synthesis-time $error.

Optional Feature:
- Macro: DEC2X4_HIT_CNT_EN.
- Defined:
  - Adds output port hit_cnt, width 4*CNT_W. Slice [k*CNT_W +: CNT_W] counts accepts of code k.
  - Each counter increments on the accept edge and saturates at all-ones; no wrap.
  - Counters reset to 0 on rst_n only. en does not clear them, and an aborted hold still counts.
- Not defined: no hit_cnt port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1, code_in=2.
  - Required: y=0000, out_valid=0, busy=0, in_ready=0 throughout.
  - Release rst_n with en=1: in_ready=1 on the next cycle.
- All codes, HOLD_CYCLES=4: send codes 0,1,2,3, each when in_ready=1.
  - Required: y=0001, 0010, 0100, 1000 in turn, each high exactly 4 cycles, 1 cycle after its accept.
  - Required: at least 1 zero cycle between pulses.
- Ignore while busy: accept code 1, then drive in_valid=1, code_in=3 for the next 3 cycles.
  - Required: y stays 0010 for 4 cycles; in_ready=0 during HOLD; 3 is accepted only when in_ready returns to 1.
- Abort: accept code 3, then drop en on the 2nd HOLD cycle.
  - Required: y=0000 on the next edge, busy=0, state IDLE; no accept while en=0.
- Async reset mid-hold: accept code 2, then pulse rst_n low between clock edges.
  - Required: y drops to 0000 immediately; after release, code 0 decodes to 0001 normally.
- DEC2X4_HIT_CNT_EN with CNT_W=2: accept code 1 five times.
  - Required: hit_cnt slice 1 reads 1,2,3,3,3 (saturates at 3); other slices stay 0.

Source files
------------

// File: rtl/decoder2x4_hold.sv
// Registered 2-to-4 one-hot decoder with valid/ready intake and programmable pulse width.
// Define DEC2X4_HIT_CNT_EN to add saturating per-line accept counters on port hit_cnt.
module decoder2x4_hold #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       code_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       y,
  output logic             out_valid,
  output logic             busy
`ifdef DEC2X4_HIT_CNT_EN
  ,
  output logic [4*CNT_W-1:0] hit_cnt
`endif
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("decoder2x4_hold: HOLD_CYCLES must be in 1..255");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("decoder2x4_hold: CNT_W must be at least 1");
  end

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t     state, nxt_state;
  logic [7:0] hold_cnt, nxt_cnt;
  logic [3:0] nxt_y;
  logic       accept;

  assign in_ready  = (state == IDLE) && en && rst_n;
  assign accept    = in_valid && in_ready;
  assign out_valid = |y;
  assign busy      = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= 8'd0;
      y        <= 4'b0000;
    end else begin
      state    <= nxt_state;
      hold_cnt <= nxt_cnt;
      y        <= nxt_y;
    end
  end

  // Dropping en in HOLD aborts the pulse outright; it never resumes.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = hold_cnt;
    nxt_y     = y;
    unique case (state)
      IDLE: begin
        if (accept) begin
          nxt_state = HOLD;
          nxt_cnt   = HOLD_LOAD;
          nxt_y     = 4'b0001 << code_in;
        end
      end
      HOLD: begin
        if (!en || hold_cnt == 8'd0) begin
          nxt_state = IDLE;
          nxt_cnt   = 8'd0;
          nxt_y     = 4'b0000;
        end else begin
          nxt_cnt = hold_cnt - 8'd1;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = 8'd0;
        nxt_y     = 4'b0000;
      end
    endcase
  end

`ifdef DEC2X4_HIT_CNT_EN
  logic [CNT_W-1:0] hit_q [4];

  // Counters saturate and survive en drops; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) hit_q[k] <= '0;
    end else if (accept && hit_q[code_in] != '1) begin
      hit_q[code_in] <= hit_q[code_in] + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_hit
    assign hit_cnt[k*CNT_W +: CNT_W] = hit_q[k];
  end
`endif

endmodule

// File: tb/tb_decoder2x4_hold.sv
// Scoreboard bench for decoder2x4_hold: stimulus queues expected pulses, a monitor checks them.
// Hit-counter checks are built only when DEC2X4_HIT_CNT_EN is defined.
module tb_decoder2x4_hold;

`ifdef DEC2X4_HIT_CNT_EN
  localparam int TB_CNT_W = 2;
`else
  localparam int TB_CNT_W = 8;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] code_in;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] y;
  logic       out_valid;
  logic       busy;
`ifdef DEC2X4_HIT_CNT_EN
  logic [4*TB_CNT_W-1:0] hit_cnt;
`endif

  typedef struct {
    logic [3:0] y;
    int         len;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  decoder2x4_hold #(
    .HOLD_CYCLES(4),
    .CNT_W      (TB_CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .code_in  (code_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y        (y),
    .out_valid(out_valid),
    .busy     (busy)
`ifdef DEC2X4_HIT_CNT_EN
    ,
    .hit_cnt  (hit_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Waits for in_ready, presents one code for a single edge and queues its expected pulse.
  task automatic apply_stimulus(input logic [1:0] code, input logic [3:0] exp_y, input int exp_len);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check_output("ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      code_in  = code;
      in_valid = 1'b1;
      sb.push_back('{y: exp_y, len: exp_len});
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  // Monitor: each pulse pops one entry; y is compared every cycle and length at the falling edge.
  initial begin : monitor
    exp_t cur;
    bit   in_pulse;
    int   len;
    in_pulse = 1'b0;
    len      = 0;
    cur      = '{y: 4'b0000, len: 0};
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (!in_pulse) begin
          if (sb.size() == 0) begin
            check_output("unexpected_pulse", 32'(y), 32'd0);
            cur = '{y: 4'b0000, len: 0};
          end else begin
            cur = sb.pop_front();
          end
          in_pulse = 1'b1;
          len      = 0;
        end
        len++;
        check_output("pulse_y", 32'(y), 32'(cur.y));
      end else if (in_pulse) begin
        check_output("pulse_len", 32'(len), 32'(cur.len));
        in_pulse = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    n_miss++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : stimulus
    rst_n    = 1'b0;
    en       = 1'b1;
    in_valid = 1'b1;
    code_in  = 2'd2;

    $display("[TB] reset hold with in_valid high");
    repeat (3) begin
      @(negedge clk);
      check_output("rst_y", 32'(y), 32'd0);
      check_output("rst_out_valid", 32'(out_valid), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check_output("post_rst_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] all codes");
    apply_stimulus(2'd0, 4'b0001, 4);
    apply_stimulus(2'd1, 4'b0010, 4);
    apply_stimulus(2'd2, 4'b0100, 4);
    apply_stimulus(2'd3, 4'b1000, 4);

    $display("[TB] ignore while busy");
    apply_stimulus(2'd1, 4'b0010, 4);
    code_in  = 2'd3;
    in_valid = 1'b1;
    sb.push_back('{y: 4'b1000, len: 4});
    repeat (3) begin
      @(negedge clk);
      check_output("busy_in_ready", 32'(in_ready), 32'd0);
      check_output("busy_flag", 32'(busy), 32'd1);
    end
    begin
      int guard;
      guard = 0;
      while (!in_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      check_output("ready_returns", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end

    $display("[TB] abort via en");
    apply_stimulus(2'd3, 4'b1000, 2);
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check_output("abort_y", 32'(y), 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_out_valid", 32'(out_valid), 32'd0);
    code_in  = 2'd2;
    in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_output("en_low_in_ready", 32'(in_ready), 32'd0);
      check_output("en_low_y", 32'(y), 32'd0);
    end
    in_valid = 1'b0;
    en       = 1'b1;

    $display("[TB] async reset mid-hold");
    apply_stimulus(2'd2, 4'b0100, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_rst_y", 32'(y), 32'd0);
    check_output("async_rst_busy", 32'(busy), 32'd0);
    #1 rst_n = 1'b1;
    apply_stimulus(2'd0, 4'b0001, 4);

`ifdef DEC2X4_HIT_CNT_EN
    $display("[TB] hit counter saturation");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_output("hit_rst", 32'(hit_cnt), 32'd0);
    begin
      logic [1:0] exp_hits [5];
      exp_hits = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      for (int i = 0; i < 5; i++) begin
        apply_stimulus(2'd1, 4'b0010, 4);
        check_output("hit_cnt", 32'(hit_cnt), 32'({2'b00, 2'b00, exp_hits[i], 2'b00}));
      end
    end
`endif

    repeat (8) @(negedge clk);
    check_output("sb_drained", 32'(sb.size()), 32'd0);
    check_output("idle_at_end", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
